frame_bank_scheduler: RTL
=========================

# frame_bank_scheduler

Controller for the DIC image-memory pair (BRAM_0, BRAM_1). It loads incoming frames into the correct bank and tracks which bank holds the reference image and which holds the deformed image as frames advance. It arbitrates single-port read access between the Gradients engine (reference only) and the Gamma engine (reference and deformed in parallel). It sits between the frame writer, the two BRAM ports and the two compute engines.

## Interface
- ADDR_W, 17, word-address width from requesters/writer
- DATA_W, 32, pixel word width
- RD_LAT, 3, cycles from BRAM address register to valid dout (≥1)

Ports:
- clock  in  1  sole clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- wr_valid, wr_last  in  1  frame-writer word strobe / last word of frame
- wr_addr  in  ADDR_W;  wr_data  in  DATA_W
- wr_ready  out  1  writer may present a word
- grad_req  in  1;  grad_addr  in  ADDR_W
- grad_ack, grad_rvalid  out  1;  grad_rdata  out  DATA_W  (reference pixel)
- gamma_req  in  1;  gamma_ref_addr, gamma_def_addr  in  ADDR_W
- gamma_ack, gamma_rvalid  out  1;  gamma_ref_data, gamma_def_data  out  DATA_W
- bram0_addr, bram1_addr  out  32  byte address = word address × 4
- bram0_we, bram1_we  out  4;  bram0_din, bram1_din  out  DATA_W
- bram0_dout, bram1_dout  in  DATA_W
- frame_count  out  32  completed frames loaded
- ref_bank  out  1  0: BRAM_0=Ref, BRAM_1=Def; 1: swapped
- pair_ready  out  1  frame_count ≥ 2

## Operation
- States: IDLE, LOAD, WAIT.
- Reset values:
  - state IDLE, frame_count 0, ref_bank 0, pair_ready 0, wr_ready 1.
  - All other outputs 0; round-robin pointer = "gamma last" so gradient wins the first tie.
  - BRAM contents are untouched.
- Load bank selection:
  - frame_count 0 → BRAM_0.
  - frame_count 1 → BRAM_1.
  - frame_count ≥ 2 → the current ref bank (oldest frame).
- IDLE → LOAD on wr_valid. Write takes priority over any pending request in the same cycle.
- LOAD:
  - Each sampled wr_valid registers the load bank's we=4'b1111, addr=wr_addr×4 and din=wr_data for one cycle. The other bank's we stays 0.
  - wr_valid with wr_last: frame_count+1. If the new count is ≥3, toggle ref_bank. Return to IDLE.
  - Requests are not granted in LOAD.
- IDLE with pair_ready=1 and no wr_valid: grant one requester and enter WAIT.
  - Round-robin between grad_req and gamma_req; the lone requester always wins.
  - Grant registers the BRAM addresses and pulses the winner's ack for 1 cycle.
- Gradient grant: only the ref bank's addr is driven = grad_addr×4.
- Gamma grant: ref bank addr = gamma_ref_addr×4, def bank addr = gamma_def_addr×4.
- WAIT:
  - Counts RD_LAT edges.
  - On the last edge, capture dout: grad_rdata = ref bank dout, or gamma_ref_data / gamma_def_data from the ref / def banks.
  - Pulse the matching rvalid for 1 cycle and return to IDLE.
- Requests with pair_ready=0 are held off. No ack, no error.
- ref_bank never toggles during WAIT, because loads cannot start there. Captured data always uses the mapping in force at grant.
- Address arithmetic: zero-extend to 32 bits, then shift left 2. No wrap.
- bramX_addr holds its last value when idle. rdata outputs hold until the next capture.
- Reset mid-operation (LOAD or WAIT):
  - Abort immediately; no rvalid.
  - frame_count is 0 and the partial frame is discarded.

## Timing
- wr_ready = 1 in IDLE and LOAD, 0 in WAIT. Writer stalls at most RD_LAT+1 cycles.
- A write sampled at edge E appears on the BRAM port in the cycle after E. Streaming sustains 1 word/cycle.
- Requester holds req and address stable until ack. ack is high in the cycle after the grant edge G.
- rvalid is high in the cycle after edge G+RD_LAT. The next grant can occur at edge G+RD_LAT+1, giving 1 read per RD_LAT+1 cycles (4 at default).
- frame_count, ref_bank and pair_ready update in the cycle after the wr_last edge. IDLE is re-entered at the same edge.

## Test plan
- Reset → all outputs 0, wr_ready=1, pair_ready=0. grad_req while pair_ready=0 → no ack for 20 cycles.
- Load frame 1 (addr 0..3, data 0xA0..0xA3), then frame 2 (0xB0..0xB3) → bram0_we=F with addr 0,4,8,12, then bram1_we=F with the same addresses. Result: frame_count=2, ref_bank=0, pair_ready=1.
- grad_req, grad_addr=5 sampled at edge G → bram0_addr=20, grad_ack in cycle G+1, grad_rvalid in cycle G+4 with grad_rdata=bram0_dout.
- gamma ref=1, def=2 → bram0_addr=4, bram1_addr=8; gamma_ref_data from BRAM_0, gamma_def_data from BRAM_1.
- Load frame 3 → writes go to BRAM_0; frame_count=3, ref_bank=1. A gamma read now drives bram1_addr=ref×4 and bram0_addr=def×4, and the returned data is swapped.
- grad_req and gamma_req held together → grants gradient, gamma, gradient at edges 0, 4, 8. wr_valid asserted in WAIT → wr_ready=0 until IDLE. reset during WAIT → no rvalid, frame_count=0.

Source files
------------

// File: rtl/frame_bank_scheduler_if.sv
// Writer and requester channels of frame_bank_scheduler.
// "master" is the writer/engine side; "slave" is the scheduler.
interface frame_bank_scheduler_if #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 32
);
  logic              wr_valid;
  logic              wr_last;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  logic              grad_req;
  logic [ADDR_W-1:0] grad_addr;
  logic              grad_ack;
  logic              grad_rvalid;
  logic [DATA_W-1:0] grad_rdata;

  logic              gamma_req;
  logic [ADDR_W-1:0] gamma_ref_addr;
  logic [ADDR_W-1:0] gamma_def_addr;
  logic              gamma_ack;
  logic              gamma_rvalid;
  logic [DATA_W-1:0] gamma_ref_data;
  logic [DATA_W-1:0] gamma_def_data;

  modport master (
    output wr_valid, wr_last, wr_addr, wr_data,
    input  wr_ready,
    output grad_req, grad_addr,
    input  grad_ack, grad_rvalid, grad_rdata,
    output gamma_req, gamma_ref_addr, gamma_def_addr,
    input  gamma_ack, gamma_rvalid, gamma_ref_data, gamma_def_data
  );

  modport slave (
    input  wr_valid, wr_last, wr_addr, wr_data,
    output wr_ready,
    input  grad_req, grad_addr,
    output grad_ack, grad_rvalid, grad_rdata,
    input  gamma_req, gamma_ref_addr, gamma_def_addr,
    output gamma_ack, gamma_rvalid, gamma_ref_data, gamma_def_data
  );
endinterface

// File: rtl/frame_bank_scheduler.sv
// Loads frames into the BRAM pair, tracks the ref/def bank mapping and
// arbitrates reads between the Gradients and Gamma engines.
module frame_bank_scheduler #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 3
) (
  input  logic              clock,
  input  logic              reset,
  frame_bank_scheduler_if.slave bus,
  output logic [31:0]       bram0_addr,
  output logic [31:0]       bram1_addr,
  output logic [3:0]        bram0_we,
  output logic [3:0]        bram1_we,
  output logic [DATA_W-1:0] bram0_din,
  output logic [DATA_W-1:0] bram1_din,
  input  logic [DATA_W-1:0] bram0_dout,
  input  logic [DATA_W-1:0] bram1_dout,
  output logic [31:0]       frame_count,
  output logic              ref_bank,
  output logic              pair_ready
);
  localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WAIT} state_t;

  state_t            state, state_n;
  logic              do_write, do_grant, pick_gamma, capture, load_bank;
  logic [31:0]       fc_inc;
  logic [CNT_W-1:0]  cnt;
  logic              rr_last_gamma, rd_gamma, rd_ref_bank;
  logic              wr_ready_q, grad_ack_q, grad_rvalid_q, gamma_ack_q, gamma_rvalid_q;
  logic [DATA_W-1:0] grad_rdata_q, gamma_ref_q, gamma_def_q;

  function automatic logic [31:0] byte_addr(input logic [ADDR_W-1:0] a);
    return 32'(a) << 2;
  endfunction

  // Next state and per-cycle actions; a write always beats a pending request.
  always_comb begin
    state_n    = state;
    do_write   = 1'b0;
    do_grant   = 1'b0;
    pick_gamma = 1'b0;
    capture    = 1'b0;
    load_bank  = (frame_count == 32'd0) ? 1'b0 :
                 (frame_count == 32'd1) ? 1'b1 : ref_bank;
    fc_inc     = frame_count + 32'd1;
    case (state)
      ST_IDLE: begin
        if (bus.wr_valid) begin
          do_write = 1'b1;
          state_n  = bus.wr_last ? ST_IDLE : ST_LOAD;
        end else if (pair_ready && (bus.grad_req || bus.gamma_req)) begin
          do_grant   = 1'b1;
          pick_gamma = bus.gamma_req && (!bus.grad_req || !rr_last_gamma);
          state_n    = ST_WAIT;
        end
      end
      ST_LOAD: begin
        if (bus.wr_valid) begin
          do_write = 1'b1;
          if (bus.wr_last) state_n = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt == CNT_W'(RD_LAT - 1)) begin
          capture = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Registered datapath: BRAM ports, frame bookkeeping, grants and captures.
  always_ff @(posedge clock) begin
    if (reset) begin
      bram0_addr     <= '0;
      bram1_addr     <= '0;
      bram0_we       <= '0;
      bram1_we       <= '0;
      bram0_din      <= '0;
      bram1_din      <= '0;
      frame_count    <= '0;
      ref_bank       <= 1'b0;
      pair_ready     <= 1'b0;
      cnt            <= '0;
      rr_last_gamma  <= 1'b1;
      rd_gamma       <= 1'b0;
      rd_ref_bank    <= 1'b0;
      wr_ready_q     <= 1'b1;
      grad_ack_q     <= 1'b0;
      grad_rvalid_q  <= 1'b0;
      gamma_ack_q    <= 1'b0;
      gamma_rvalid_q <= 1'b0;
      grad_rdata_q   <= '0;
      gamma_ref_q    <= '0;
      gamma_def_q    <= '0;
    end else begin
      bram0_we       <= '0;
      bram1_we       <= '0;
      grad_ack_q     <= 1'b0;
      gamma_ack_q    <= 1'b0;
      grad_rvalid_q  <= 1'b0;
      gamma_rvalid_q <= 1'b0;
      wr_ready_q     <= (state_n != ST_WAIT);

      if (do_write) begin
        if (load_bank) begin
          bram1_we   <= 4'b1111;
          bram1_addr <= byte_addr(bus.wr_addr);
          bram1_din  <= bus.wr_data;
        end else begin
          bram0_we   <= 4'b1111;
          bram0_addr <= byte_addr(bus.wr_addr);
          bram0_din  <= bus.wr_data;
        end
        if (bus.wr_last) begin
          frame_count <= fc_inc;
          pair_ready  <= (fc_inc >= 32'd2);
          if (fc_inc >= 32'd3) ref_bank <= ~ref_bank;
        end
      end

      if (do_grant) begin
        cnt           <= '0;
        rd_gamma      <= pick_gamma;
        rd_ref_bank   <= ref_bank;
        rr_last_gamma <= pick_gamma;
        if (pick_gamma) begin
          gamma_ack_q <= 1'b1;
          if (ref_bank) begin
            bram1_addr <= byte_addr(bus.gamma_ref_addr);
            bram0_addr <= byte_addr(bus.gamma_def_addr);
          end else begin
            bram0_addr <= byte_addr(bus.gamma_ref_addr);
            bram1_addr <= byte_addr(bus.gamma_def_addr);
          end
        end else begin
          grad_ack_q <= 1'b1;
          if (ref_bank) bram1_addr <= byte_addr(bus.grad_addr);
          else          bram0_addr <= byte_addr(bus.grad_addr);
        end
      end

      if (state == ST_WAIT && !capture) cnt <= CNT_W'(cnt + 1'b1);

      // Capture uses the bank mapping latched at grant time.
      if (capture) begin
        if (rd_gamma) begin
          gamma_ref_q    <= rd_ref_bank ? bram1_dout : bram0_dout;
          gamma_def_q    <= rd_ref_bank ? bram0_dout : bram1_dout;
          gamma_rvalid_q <= 1'b1;
        end else begin
          grad_rdata_q  <= rd_ref_bank ? bram1_dout : bram0_dout;
          grad_rvalid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.wr_ready       = wr_ready_q;
  assign bus.grad_ack       = grad_ack_q;
  assign bus.grad_rvalid    = grad_rvalid_q;
  assign bus.grad_rdata     = grad_rdata_q;
  assign bus.gamma_ack      = gamma_ack_q;
  assign bus.gamma_rvalid   = gamma_rvalid_q;
  assign bus.gamma_ref_data = gamma_ref_q;
  assign bus.gamma_def_data = gamma_def_q;
endmodule
